// File: rtl/cpu_control_fsm_if.sv
// Control bundle between the CPU controller, instruction decoder and datapath.
// Latency: n/a (wires only).
// Backpressure: none; the controller strobes every cycle.
//
// opcode/op : decoded instruction fields, driven by the decoder side
// nsel      : register select returned to the decoder
// loada/b/c, loads, write, asel, bsel, vsel : datapath strobes and selects
// load_ir, load_pc, reset_pc, addr_sel, load_addr, mem_cmd : fetch/memory control
// halted    : controller is parked in HALT
interface cpu_control_fsm_if;
  logic [2:0] opcode;
  logic [1:0] op;
  logic [1:0] nsel;
  logic       loada;
  logic       loadb;
  logic       loadc;
  logic       loads;
  logic       write;
  logic       asel;
  logic       bsel;
  logic [1:0] vsel;
  logic       load_ir;
  logic       load_pc;
  logic       reset_pc;
  logic       addr_sel;
  logic       load_addr;
  logic [1:0] mem_cmd;
  logic       halted;

  // Controller side.
  modport master (
    input  opcode, op,
    output nsel, loada, loadb, loadc, loads, write, asel, bsel, vsel,
           load_ir, load_pc, reset_pc, addr_sel, load_addr, mem_cmd, halted
  );

  // Decoder/datapath side.
  modport slave (
    output opcode, op,
    input  nsel, loada, loadb, loadc, loads, write, asel, bsel, vsel,
           load_ir, load_pc, reset_pc, addr_sel, load_addr, mem_cmd, halted
  );
endinterface

// File: rtl/cpu_control_fsm.sv
// Moore controller sequencing fetch/decode/execute/write-back of the 16-bit CPU.
// Latency: outputs registered, valid in the cycle the state is occupied; 4..10 cycles per instruction.
// Backpressure: none; memory is assumed to answer in fixed time, HALT parks until reset.
//
// Ports: clk (rising edge), reset (synchronous, active-high),
//        ctl (cpu_control_fsm_if.master): opcode/op in, all datapath/fetch/memory strobes out.
module cpu_control_fsm (
  input  logic                      clk,
  input  logic                      reset,
  cpu_control_fsm_if.master         ctl
);

  localparam logic [1:0] NSEL_RN    = 2'b00;
  localparam logic [1:0] NSEL_RD    = 2'b01;
  localparam logic [1:0] NSEL_RM    = 2'b10;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_IMM8  = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;

  localparam logic [1:0] MEM_NONE   = 2'b00;
  localparam logic [1:0] MEM_READ   = 2'b01;
  localparam logic [1:0] MEM_WRITE  = 2'b10;

  typedef enum logic [4:0] {
    S_RST, S_IF1, S_IF2, S_UPD_PC, S_DECODE,
    S_WR_IMM, S_GET_A, S_GET_B, S_ALU, S_WR_REG,
    S_MEM_ADDR, S_LD_ADDR, S_MEM_RD, S_MEM_WB,
    S_GET_RD, S_STR_C, S_MEM_WR, S_HALT
  } state_e;

  typedef struct packed {
    logic [1:0] nsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       write;
    logic       asel;
    logic       bsel;
    logic [1:0] vsel;
    logic       load_ir;
    logic       load_pc;
    logic       reset_pc;
    logic       addr_sel;
    logic       load_addr;
    logic [1:0] mem_cmd;
    logic       halted;
  } ctrl_t;

  state_e state_q, state_d;
  ctrl_t  ctrl_q,  ctrl_d;

  // Output word for a state. The ALU state looks at the instruction fields,
  // which the IR holds stable from UPD_PC until the next fetch.
  function automatic ctrl_t ctrl_for(state_e s, logic [2:0] opc, logic [1:0] o);
    ctrl_t c;
    c         = '0;
    c.nsel    = NSEL_RN;
    c.vsel    = VSEL_C;
    c.mem_cmd = MEM_NONE;
    case (s)
      S_RST: begin
        c.reset_pc = 1'b1;
        c.load_pc  = 1'b1;
      end
      S_IF1: begin
        c.addr_sel = 1'b1;
        c.mem_cmd  = MEM_READ;
      end
      S_IF2: begin
        c.addr_sel = 1'b1;
        c.mem_cmd  = MEM_READ;
        c.load_ir  = 1'b1;
      end
      S_UPD_PC:   c.load_pc = 1'b1;
      S_WR_IMM: begin
        c.nsel  = NSEL_RN;
        c.vsel  = VSEL_IMM8;
        c.write = 1'b1;
      end
      S_GET_A: begin
        c.nsel  = NSEL_RN;
        c.loada = 1'b1;
      end
      S_GET_B: begin
        c.nsel  = NSEL_RM;
        c.loadb = 1'b1;
      end
      S_ALU: begin
        // MOV reg and MVN pass only B through the ALU, so force A to zero.
        c.asel = ((opc == 3'b110) && (o == 2'b00)) || ((opc == 3'b101) && (o == 2'b11));
        if ((opc == 3'b101) && (o == 2'b01)) c.loads = 1'b1;  // CMP: flags only
        else                                 c.loadc = 1'b1;
      end
      S_WR_REG: begin
        c.nsel  = NSEL_RD;
        c.vsel  = VSEL_C;
        c.write = 1'b1;
      end
      S_MEM_ADDR: begin
        c.bsel  = 1'b1;
        c.loadc = 1'b1;
      end
      S_LD_ADDR:  c.load_addr = 1'b1;
      S_MEM_RD:   c.mem_cmd   = MEM_READ;
      S_MEM_WB: begin
        c.mem_cmd = MEM_READ;
        c.nsel    = NSEL_RD;
        c.vsel    = VSEL_MDATA;
        c.write   = 1'b1;
      end
      S_GET_RD: begin
        c.nsel  = NSEL_RD;
        c.loadb = 1'b1;
      end
      S_STR_C: begin
        // Rd travels to the store data path through B with A forced to zero.
        c.asel  = 1'b1;
        c.loadc = 1'b1;
      end
      S_MEM_WR:   c.mem_cmd = MEM_WRITE;
      S_HALT:     c.halted  = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:    state_d = S_IF1;
      S_IF1:    state_d = S_IF2;
      S_IF2:    state_d = S_UPD_PC;
      S_UPD_PC: state_d = S_DECODE;
      S_DECODE: begin
        case (ctl.opcode)
          3'b111: state_d = S_HALT;
          3'b110: begin
            if      (ctl.op == 2'b10) state_d = S_WR_IMM;
            else if (ctl.op == 2'b00) state_d = S_GET_B;
            else                      state_d = S_IF1;  // illegal: NOP
          end
          3'b101:         state_d = (ctl.op == 2'b11) ? S_GET_B : S_GET_A;
          3'b011, 3'b100: state_d = S_GET_A;
          default:        state_d = S_IF1;              // illegal: NOP
        endcase
      end
      S_WR_IMM:   state_d = S_IF1;
      S_GET_A:    state_d = ((ctl.opcode == 3'b011) || (ctl.opcode == 3'b100)) ? S_MEM_ADDR : S_GET_B;
      S_GET_B:    state_d = S_ALU;
      S_ALU:      state_d = ((ctl.opcode == 3'b101) && (ctl.op == 2'b01)) ? S_IF1 : S_WR_REG;
      S_WR_REG:   state_d = S_IF1;
      S_MEM_ADDR: state_d = S_LD_ADDR;
      S_LD_ADDR:  state_d = (ctl.opcode == 3'b011) ? S_MEM_RD : S_GET_RD;
      S_MEM_RD:   state_d = S_MEM_WB;
      S_MEM_WB:   state_d = S_IF1;
      S_GET_RD:   state_d = S_STR_C;
      S_STR_C:    state_d = S_MEM_WR;
      S_MEM_WR:   state_d = S_IF1;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_RST;                      // unreachable encodings recover
    endcase
    // Outputs are computed for the next state so they are registered yet
    // still describe the state being occupied.
    ctrl_d = ctrl_for(state_d, ctl.opcode, ctl.op);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RST;
      ctrl_q  <= ctrl_for(S_RST, 3'b000, 2'b00);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign ctl.nsel      = ctrl_q.nsel;
  assign ctl.loada     = ctrl_q.loada;
  assign ctl.loadb     = ctrl_q.loadb;
  assign ctl.loadc     = ctrl_q.loadc;
  assign ctl.loads     = ctrl_q.loads;
  assign ctl.write     = ctrl_q.write;
  assign ctl.asel      = ctrl_q.asel;
  assign ctl.bsel      = ctrl_q.bsel;
  assign ctl.vsel      = ctrl_q.vsel;
  assign ctl.load_ir   = ctrl_q.load_ir;
  assign ctl.load_pc   = ctrl_q.load_pc;
  assign ctl.reset_pc  = ctrl_q.reset_pc;
  assign ctl.addr_sel  = ctrl_q.addr_sel;
  assign ctl.load_addr = ctrl_q.load_addr;
  assign ctl.mem_cmd   = ctrl_q.mem_cmd;
  assign ctl.halted    = ctrl_q.halted;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Bench for cpu_control_fsm: directed instruction table, hand-written reset/HALT
// sequences, then random instruction streams against a per-instruction trace model.
module tb_cpu_control_fsm;

  typedef logic [18:0] ov_t;

  // Bit masks of the packed output word (see sample()).
  localparam ov_t HALTED   = 19'd1 << 0;
  localparam ov_t MRD      = 19'd1 << 1;
  localparam ov_t MWR      = 19'd2 << 1;
  localparam ov_t LD_ADDR  = 19'd1 << 3;
  localparam ov_t ADDR_SEL = 19'd1 << 4;
  localparam ov_t RESET_PC = 19'd1 << 5;
  localparam ov_t LOAD_PC  = 19'd1 << 6;
  localparam ov_t LOAD_IR  = 19'd1 << 7;
  localparam ov_t V_IMM    = 19'd2 << 8;
  localparam ov_t V_MD     = 19'd3 << 8;
  localparam ov_t BSEL     = 19'd1 << 10;
  localparam ov_t ASEL     = 19'd1 << 11;
  localparam ov_t WRITE    = 19'd1 << 12;
  localparam ov_t LOADS    = 19'd1 << 13;
  localparam ov_t LOADC    = 19'd1 << 14;
  localparam ov_t LOADB    = 19'd1 << 15;
  localparam ov_t LOADA    = 19'd1 << 16;
  localparam ov_t N_RD     = 19'd1 << 17;
  localparam ov_t N_RM     = 19'd2 << 17;

  localparam ov_t RST_W = RESET_PC | LOAD_PC;
  localparam ov_t IF1_W = ADDR_SEL | MRD;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  ov_t  exp_q[$];

  cpu_control_fsm_if bus ();

  cpu_control_fsm dut (
    .clk   (clk),
    .reset (reset),
    .ctl   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ov_t sample();
    return {bus.nsel, bus.loada, bus.loadb, bus.loadc, bus.loads, bus.write,
            bus.asel, bus.bsel, bus.vsel, bus.load_ir, bus.load_pc, bus.reset_pc,
            bus.addr_sel, bus.load_addr, bus.mem_cmd, bus.halted};
  endfunction

  task automatic check(input string name, input ov_t got, input ov_t want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%05h want=%05h", name, got, want);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", name, got, want);
    end
  endtask

  // Compares one sampled cycle and the two structural invariants.
  task automatic check_cycle(input string name, input ov_t want);
    ov_t g;
    int  n;
    g = sample();
    check(name, g, want);
    n = int'(g[12]) + int'(g[7]) + ((g[2:1] == 2'b10) ? 1 : 0);
    check_int({name, " excl"}, (n > 1) ? 1 : 0, 0);
    check_int({name, " c+s"}, int'(g[14] & g[13]), 0);
  endtask

  // Reference trace of one instruction from its IF1 to just before the next IF1,
  // built from the instruction class rules.
  task automatic build_trace(input logic [2:0] opc, input logic [1:0] o);
    exp_q.delete();
    exp_q.push_back(IF1_W);
    exp_q.push_back(IF1_W | LOAD_IR);
    exp_q.push_back(LOAD_PC);
    exp_q.push_back('0);
    if (opc == 3'd7) return;
    if (opc == 3'd6 && o == 2'd2) begin
      exp_q.push_back(V_IMM | WRITE);
    end else if ((opc == 3'd6 && o == 2'd0) || (opc == 3'd5 && o == 2'd3)) begin
      exp_q.push_back(N_RM | LOADB);
      exp_q.push_back(ASEL | LOADC);
      exp_q.push_back(N_RD | WRITE);
    end else if (opc == 3'd5) begin
      exp_q.push_back(LOADA);
      exp_q.push_back(N_RM | LOADB);
      if (o == 2'd1) exp_q.push_back(LOADS);
      else begin
        exp_q.push_back(LOADC);
        exp_q.push_back(N_RD | WRITE);
      end
    end else if (opc == 3'd3 || opc == 3'd4) begin
      exp_q.push_back(LOADA);
      exp_q.push_back(BSEL | LOADC);
      exp_q.push_back(LD_ADDR);
      if (opc == 3'd3) begin
        exp_q.push_back(MRD);
        exp_q.push_back(MRD | N_RD | V_MD | WRITE);
      end else begin
        exp_q.push_back(N_RD | LOADB);
        exp_q.push_back(ASEL | LOADC);
        exp_q.push_back(MWR);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Entered at a negedge while the DUT is in IF1. Runs one instruction until IF1
  // reappears (bounded), returning the cycle count and the last-cycle outputs.
  task automatic run_instr(input logic [2:0] opc, input logic [1:0] o,
                           output int cyc, output ov_t last);
    ov_t g;
    bus.opcode = opc;
    bus.op     = o;
    build_trace(opc, o);
    cyc  = 0;
    last = '0;
    do begin
      g = sample();
      if (cyc < exp_q.size())
        check_cycle($sformatf("i%0d/%0d c%0d", opc, o, cyc), exp_q[cyc]);
      last = g;
      step();
      cyc++;
    end while (sample() != IF1_W && cyc < 32);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    step();
    check_cycle({tag, " rst"}, RST_W);
    reset = 1'b0;
    step();
    check_cycle({tag, " if1"}, IF1_W);
  endtask

  task automatic partial_reset(input logic [2:0] opc, input logic [1:0] o, input int k);
    bus.opcode = opc;
    bus.op     = o;
    build_trace(opc, o);
    for (int i = 0; i < k; i++) begin
      check_cycle($sformatf("p%0d/%0d c%0d", opc, o, i), exp_q[i]);
      if (i < k - 1) step();
    end
    do_reset("mid");
  endtask

  task automatic halt_seq(input logic [1:0] o, input int hold);
    bus.opcode = 3'd7;
    bus.op     = o;
    build_trace(3'd7, o);
    for (int i = 0; i < 4; i++) begin
      check_cycle($sformatf("halt f%0d", i), exp_q[i]);
      step();
    end
    for (int i = 0; i < hold; i++) begin
      check_cycle($sformatf("halt h%0d", i), HALTED);
      step();
    end
    do_reset("halt");
  endtask

  typedef struct {
    logic [2:0] opc;
    logic [1:0] op;
    int         cycles;
    ov_t        last;
    string      name;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int  cyc;
    ov_t last;
    int  r;
    logic [2:0] ropc;
    logic [1:0] rop;

    vecs[0]  = '{3'd6, 2'd2, 5,  V_IMM | WRITE,                  "movimm"};
    vecs[1]  = '{3'd5, 2'd0, 8,  N_RD | WRITE,                   "add"};
    vecs[2]  = '{3'd5, 2'd1, 7,  LOADS,                          "cmp"};
    vecs[3]  = '{3'd6, 2'd0, 7,  N_RD | WRITE,                   "movreg"};
    vecs[4]  = '{3'd5, 2'd3, 7,  N_RD | WRITE,                   "mvn"};
    vecs[5]  = '{3'd5, 2'd2, 8,  N_RD | WRITE,                   "and"};
    vecs[6]  = '{3'd3, 2'd0, 9,  MRD | N_RD | V_MD | WRITE,      "ldr"};
    vecs[7]  = '{3'd4, 2'd0, 10, MWR,                            "str"};
    vecs[8]  = '{3'd0, 2'd0, 4,  19'd0,                          "ill000"};
    vecs[9]  = '{3'd6, 2'd1, 4,  19'd0,                          "ill110_01"};
    vecs[10] = '{3'd2, 2'd3, 4,  19'd0,                          "ill010"};

    reset      = 1'b1;
    bus.opcode = 3'd0;
    bus.op     = 2'd0;
    @(posedge clk);
    @(negedge clk);
    check_cycle("reset state", RST_W);
    reset = 1'b0;
    step();
    check_cycle("first if1", IF1_W);

    foreach (vecs[i]) begin
      run_instr(vecs[i].opc, vecs[i].op, cyc, last);
      check_int({vecs[i].name, " cycles"}, cyc, vecs[i].cycles);
      check({vecs[i].name, " last"}, last, vecs[i].last);
    end

    // Reset during GET_B of an ADD (IF1,IF2,UPD_PC,DECODE,GET_A,GET_B).
    partial_reset(3'd5, 2'd0, 6);

    // HALT holds with no strobes, then reset restarts fetch.
    halt_seq(2'd0, 24);

    // Random instruction stream, occasional mid-instruction resets and halts.
    for (int n = 0; n < 300; n++) begin
      r    = $urandom_range(0, 19);
      ropc = 3'($urandom_range(0, 6));
      rop  = 2'($urandom_range(0, 3));
      if (r == 0) begin
        halt_seq(rop, $urandom_range(1, 6));
      end else if (r <= 2) begin
        build_trace(ropc, rop);
        partial_reset(ropc, rop, $urandom_range(1, exp_q.size()));
      end else begin
        run_instr(ropc, rop, cyc, last);
        build_trace(ropc, rop);
        check_int($sformatf("rnd %0d/%0d cycles", ropc, rop), cyc, exp_q.size());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cpu_control_fsm.md
Name: cpu_control_fsm

Overview:
- Moore-style controller that sequences the single-cycle-register datapath, register file and memory interface of the 16-bit CPU.
- Takes opcode/op from the instruction decoder and drives:
  - nsel back into the decoder
  - load/select strobes into the datapath
  - PC/IR/address-register control and memory commands
- Executes one instruction at a time: fetch → decode → execute → write-back. Halts on HALT until reset.

Parameters:
- None. State encoding is internal. Output encodings come from the shared constants file (Rn, Rd, Rm, DP, DT opcode classes).

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high; forces state RST at next edge
opcode  input  3  from instruction decoder (instruction[15:13])
op  input  2  from instruction decoder (instruction[12:11])
nsel  output  2  register select to decoder: Rn, Rd, Rm (shared constants)
loada  output  1  load datapath A register
loadb  output  1  load datapath B register
loadc  output  1  load datapath C register
loads  output  1  load status flags
write  output  1  register-file write enable
asel  output  1  1 = ALU A input forced to 0
bsel  output  1  1 = ALU B input is sximm5
vsel  output  2  write-back source: 00 C, 01 PC, 10 sximm8, 11 mdata
load_ir  output  1  load instruction register
load_pc  output  1  load program counter
reset_pc  output  1  PC next-value mux selects 0
addr_sel  output  1  1 = memory address from PC, 0 = from address register
load_addr  output  1  load data-address register from C
mem_cmd  output  2  00 NONE, 01 READ, 10 WRITE
halted  output  1  high while in HALT

Behaviour:
- Outputs are pure functions of the current state (Moore).
- Every output not listed for a state is 0. nsel defaults to Rn. vsel defaults to 00.
- On reset (sampled at posedge): next state is RST, from any state, including mid-instruction and HALT.
- In the cycle after reset asserts, all outputs equal the RST values.

State list (outputs → next state):
- RST: reset_pc=1, load_pc=1 → IF1.
- IF1: addr_sel=1, mem_cmd=READ → IF2.
- IF2: addr_sel=1, mem_cmd=READ, load_ir=1 → UPD_PC.
- UPD_PC: load_pc=1 (PC+1) → DECODE.
- DECODE: no strobes. Transitions:
  - 111 → HALT
  - 110/op10 (MOV imm) → WR_IMM
  - 110/op00 (MOV reg) → GET_B
  - 101/op11 (MVN) → GET_B
  - 101 other op (ADD/CMP/AND) → GET_A
  - 011 (LDR) or 100 (STR) → GET_A
  - any other opcode/op (illegal) → IF1, executed as NOP.
- WR_IMM: nsel=Rn, vsel=10, write=1 → IF1.
- GET_A: nsel=Rn, loada=1 → MEM_ADDR if opcode is 011/100, else GET_B.
- GET_B: nsel=Rm, loadb=1 → ALU.
- ALU: asel=1 for MOV reg and MVN, else 0; bsel=0. Then:
  - CMP (101/op01): loads=1, loadc=0 → IF1.
  - otherwise: loadc=1 → WR_REG.
- WR_REG: nsel=Rd, vsel=00, write=1 → IF1.
- MEM_ADDR: asel=0, bsel=1, loadc=1 → LD_ADDR.
- LD_ADDR: load_addr=1 → MEM_RD (LDR) or GET_RD (STR).
- MEM_RD: addr_sel=0, mem_cmd=READ → MEM_WB.
- MEM_WB: addr_sel=0, mem_cmd=READ, nsel=Rd, vsel=11, write=1 → IF1.
- GET_RD: nsel=Rd, loadb=1 → STR_C.
- STR_C: asel=1, bsel=0, loadc=1 → MEM_WR.
- MEM_WR: addr_sel=0, mem_cmd=WRITE → IF1.
- HALT: halted=1. Stays in HALT until reset.

Timing and invariants:
- opcode/op are valid from UPD_PC onward and remain stable until the next IF2, because IR changes only on load_ir. Post-DECODE states may therefore re-read them.
- Cycle counts from IF1 to the next IF1:
  - MOV imm 5
  - MOV reg / MVN / CMP 7
  - ADD / AND 8
  - LDR 9
  - STR 10
  - illegal 4
  - RST adds 1 cycle before the first IF1.
- At most one of write, load_ir and mem_cmd=WRITE is asserted in any state.
- Never assert loadc and loads together.
- Unreachable state encodings → RST on the next edge.

Test Plan:
- Reset mid-ADD (assert reset in GET_B) → next cycle reset_pc=1, load_pc=1, all other strobes 0; then IF1 with addr_sel=1, mem_cmd=01.
- Fetch then MOV imm (opcode 110, op 10) → exactly 5 cycles IF1..WR_IMM; WR_IMM shows nsel=Rn, vsel=10, write=1.
- ADD (101/00) then CMP (101/01) → ADD writes with nsel=Rd, vsel=00 in cycle 8; CMP pulses loads=1 in the ALU cycle, no write, returns to IF1 after 7 cycles.
- MVN (101/11) → GET_A skipped; ALU cycle shows asel=1, loadc=1.
- LDR (011/00) → sequence GET_A, MEM_ADDR (bsel=1), LD_ADDR (load_addr=1), MEM_RD, MEM_WB (addr_sel=0, mem_cmd=01, vsel=11, write=1).
- STR (100/00) → GET_RD (nsel=Rd, loadb=1), STR_C (asel=1), MEM_WR (mem_cmd=10, write=0).
- HALT (111) → halted=1 held for 20+ cycles with no strobes; reset → RST then IF1.
- Illegal opcode 000 → DECODE returns to IF1 with no write or memory write.
